// File: rtl/filtro_biquad_mc_pkg.sv
// Shared types and defaults for the time-multiplexed biquad section.
package filtro_biquad_mc_pkg;

  localparam int unsigned DefN    = 16;
  localparam int unsigned DefFrac = 14;
  localparam int unsigned DefNch  = 2;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StFa1  = 4'd1,
    StFa2  = 4'd2,
    StFsat = 4'd3,
    StYb0  = 4'd4,
    StYb1  = 4'd5,
    StYb2  = 4'd6,
    StUpd  = 4'd7,
    StOut  = 4'd8
  } state_e;

  typedef enum logic {
    MacAdd = 1'b0,
    MacSub = 1'b1
  } mac_op_e;

endpackage

// File: rtl/filtro_biquad_mc_mac_sat.sv
// Shared multiply-accumulate step plus round-and-saturate of the current accumulator.
module filtro_biquad_mc_mac_sat
  import filtro_biquad_mc_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned FRAC = DefFrac,
  parameter int unsigned ACCW = 2 * N + 3
) (
  input  logic signed [N-1:0]    mul_a_i,
  input  logic signed [N-1:0]    mul_b_i,
  input  mac_op_e                op_i,
  input  logic signed [ACCW-1:0] acc_i,
  output logic signed [ACCW-1:0] acc_o,
  output logic signed [N-1:0]    sat_o,
  output logic                   ovf_o
);

  localparam int unsigned RW = ACCW - FRAC;
  localparam logic signed [ACCW-1:0] Half = ACCW'(2 ** (FRAC - 1));
  localparam logic signed [RW-1:0] SatMax = {{(RW - N + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [RW-1:0] SatMin = {{(RW - N + 1){1'b1}}, {(N - 1){1'b0}}};

  logic signed [2*N-1:0]  prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] rnd_sum;
  logic signed [RW-1:0]   rnd_val;

  assign prod     = mul_a_i * mul_b_i;
  assign prod_ext = {{(ACCW - 2 * N){prod[2*N-1]}}, prod};
  assign acc_o    = (op_i == MacSub) ? acc_i - prod_ext : acc_i + prod_ext;

  // Dropping the low FRAC bits of a signed value is an arithmetic shift right.
  assign rnd_sum = acc_i + Half;
  assign rnd_val = rnd_sum[ACCW-1:FRAC];

  always_comb begin
    sat_o = rnd_val[N-1:0];
    ovf_o = 1'b0;
    if (rnd_val > SatMax) begin
      sat_o = {1'b0, {(N - 1){1'b1}}};
      ovf_o = 1'b1;
    end else if (rnd_val < SatMin) begin
      sat_o = {1'b1, {(N - 1){1'b0}}};
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/filtro_biquad_mc.sv
// Multi-channel direct-form-II biquad: one shared MAC, per-channel f(k-1)/f(k-2) history.
module filtro_biquad_mc
  import filtro_biquad_mc_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned FRAC = DefFrac,
  parameter int unsigned NCH  = DefNch,
  parameter int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int unsigned ACCW = 2 * N + 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CHW-1:0]      in_ch,
  input  logic signed [N-1:0] uk,
  input  logic signed [N-1:0] b0,
  input  logic signed [N-1:0] b1,
  input  logic signed [N-1:0] b2,
  input  logic signed [N-1:0] a1,
  input  logic signed [N-1:0] a2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CHW-1:0]      out_ch,
  output logic signed [N-1:0] yk,
  output logic                ovf
);

  state_e state_q, state_d;

  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic signed [N-1:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
  logic signed [N-1:0]    fk_q, fk_d;
  logic                   ovf_f_q, ovf_f_d;
  logic signed [N-1:0]    yk_q, yk_d;
  logic [CHW-1:0]         out_ch_q, out_ch_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;
  logic signed [N-1:0]    f1_q [NCH];
  logic signed [N-1:0]    f1_d [NCH];
  logic signed [N-1:0]    f2_q [NCH];
  logic signed [N-1:0]    f2_d [NCH];

  logic signed [N-1:0]    mul_a, mul_b;
  mac_op_e                mac_op;
  logic signed [ACCW-1:0] mac_acc;
  logic signed [N-1:0]    mac_sat;
  logic                   mac_ovf;

  filtro_biquad_mc_mac_sat #(
    .N   (N),
    .FRAC(FRAC),
    .ACCW(ACCW)
  ) u_mac_sat (
    .mul_a_i(mul_a),
    .mul_b_i(mul_b),
    .op_i   (mac_op),
    .acc_i  (acc_q),
    .acc_o  (mac_acc),
    .sat_o  (mac_sat),
    .ovf_o  (mac_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (in_valid) state_d = StFa1;
        StFa1:   state_d = StFa2;
        StFa2:   state_d = StFsat;
        StFsat:  state_d = StYb0;
        StYb0:   state_d = StYb1;
        StYb1:   state_d = StYb2;
        StYb2:   state_d = StUpd;
        StUpd:   state_d = StOut;
        StOut:   if (out_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: handshake and MAC operand select
  always_comb begin
    in_ready = (state_q == StIdle) && !clr;
    mul_a    = '0;
    mul_b    = '0;
    mac_op   = MacAdd;
    case (state_q)
      StFa1: begin mul_a = a1_q; mul_b = f1_q[ch_q]; mac_op = MacSub; end
      StFa2: begin mul_a = a2_q; mul_b = f2_q[ch_q]; mac_op = MacSub; end
      StYb0: begin mul_a = b0_q; mul_b = fk_q; end
      StYb1: begin mul_a = b1_q; mul_b = f1_q[ch_q]; end
      StYb2: begin mul_a = b2_q; mul_b = f2_q[ch_q]; end
      default: ;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    ch_d        = ch_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    fk_d        = fk_q;
    ovf_f_d     = ovf_f_q;
    yk_d        = yk_q;
    out_ch_d    = out_ch_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    f1_d        = f1_q;
    f2_d        = f2_q;
    if (clr) begin
      acc_d       = '0;
      out_valid_d = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        f1_d[i] = '0;
        f2_d[i] = '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Out-of-range channel numbers fold onto channel 0.
            ch_d  = (32'(in_ch) < NCH) ? in_ch : '0;
            b0_d  = b0;
            b1_d  = b1;
            b2_d  = b2;
            a1_d  = a1;
            a2_d  = a2;
            acc_d = {{(ACCW - N - FRAC){uk[N-1]}}, uk, {FRAC{1'b0}}};
          end
        end
        StFa1, StFa2, StYb0, StYb1, StYb2: acc_d = mac_acc;
        StFsat: begin
          fk_d    = mac_sat;
          ovf_f_d = mac_ovf;
          acc_d   = '0;
        end
        StUpd: begin
          yk_d        = mac_sat;
          ovf_d       = ovf_f_q | mac_ovf;
          f2_d[ch_q]  = f1_q[ch_q];
          f1_d[ch_q]  = fk_q;
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
        end
        StOut: if (out_ready) out_valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      ch_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      fk_q        <= '0;
      ovf_f_q     <= 1'b0;
      yk_q        <= '0;
      out_ch_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      f1_q        <= '{default: '0};
      f2_q        <= '{default: '0};
    end else begin
      acc_q       <= acc_d;
      ch_q        <= ch_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      fk_q        <= fk_d;
      ovf_f_q     <= ovf_f_d;
      yk_q        <= yk_d;
      out_ch_q    <= out_ch_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      f1_q        <= f1_d;
      f2_q        <= f2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign yk        = yk_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_filtro_biquad_mc.sv
// Bench for filtro_biquad_mc: directed filter cases plus random samples against a math model.
module tb_filtro_biquad_mc;

  localparam int N    = 16;
  localparam int FRAC = 14;
  localparam int NCH  = 2;
  localparam int CHW  = 1;

  logic                clk = 1'b0;
  logic                reset, clr, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [CHW-1:0]      in_ch, out_ch;
  logic signed [N-1:0] uk, b0, b1, b2, a1, a2, yk;
  logic signed [N-1:0] cb0, cb1, cb2, ca1, ca2;

  int     tests = 0;
  int     fails = 0;
  longint mf1 [NCH];
  longint mf2 [NCH];

  always #5 clk = ~clk;

  filtro_biquad_mc dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .uk       (uk),
    .b0       (b0),
    .b1       (b1),
    .b2       (b2),
    .a1       (a1),
    .a2       (a2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .yk       (yk),
    .ovf      (ovf)
  );

  task automatic set_coefs(input int v0, input int v1, input int v2, input int w1, input int w2);
    cb0 = 16'(v0); cb1 = 16'(v1); cb2 = 16'(v2); ca1 = 16'(w1); ca2 = 16'(w2);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      mf1[i] = 0;
      mf2[i] = 0;
    end
  endtask

  function automatic longint rnd_sat(input longint x, output bit o);
    longint r;
    r = (x + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    o = 1'b0;
    if (r > 32767) begin
      r = 32767;  o = 1'b1;
    end else if (r < -32768) begin
      r = -32768; o = 1'b1;
    end
    return r;
  endfunction

  // f(k) = u - a1 f(k-1) - a2 f(k-2); y(k) = b0 f(k) + b1 f(k-1) + b2 f(k-2)
  function automatic void model_step(input int ch, input longint u, output longint y,
                                     output bit o);
    longint f;
    bit     of, oy;
    f = rnd_sat(u * 16384 - longint'(ca1) * mf1[ch] - longint'(ca2) * mf2[ch], of);
    y = rnd_sat(longint'(cb0) * f + longint'(cb1) * mf1[ch] + longint'(cb2) * mf2[ch], oy);
    mf2[ch] = mf1[ch];
    mf1[ch] = f;
    o = of | oy;
  endfunction

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clear();
  endtask

  // lat counts whole cycles from the accepting cycle to the first cycle with out_valid high.
  task automatic run_sample(input int ch, input int u, output longint y, output int oc,
                            output bit ov, output int lat, output bit tmo);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; in_ch = CHW'(ch); uk = 16'(u);
    b0 = cb0; b1 = cb1; b2 = cb2; a1 = ca1; a2 = ca2;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    tmo = !in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    // Scrambled coefficient ports must not disturb the sample in flight.
    b0 = 16'($urandom); b1 = 16'($urandom); b2 = 16'($urandom);
    a1 = 16'($urandom); a2 = 16'($urandom); uk = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) tmo = 1'b1;
    y  = longint'(yk);
    oc = int'(out_ch);
    ov = ovf;
  endtask

  task automatic test_reset();
    tests++;
    if (out_valid !== 1'b0 || yk !== 16'sd0 || out_ch !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b yk=%0d ch=%0d ovf=%b, want 0 0 0 0",
               out_valid, yk, out_ch, ovf);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_passthrough();
    longint y; int oc, lat; bit ov, tmo;
    do_clr();
    set_coefs(16384, 0, 0, 0, 0);
    run_sample(0, 1000, y, oc, ov, lat, tmo);
    tests++;
    if (tmo || y !== 1000 || ov !== 1'b0 || oc !== 0) begin
      fails++;
      $display("FAIL passthrough: got yk=%0d ovf=%b ch=%0d tmo=%b, want 1000 0 0 0", y, ov, oc, tmo);
    end
    tests++;
    if (lat !== 8) begin
      fails++;
      $display("FAIL latency: got %0d cycles want 8", lat);
    end
  endtask

  task automatic test_fir();
    longint y; int oc, lat; bit ov, tmo;
    int exp_y [2] = '{500, 2000};
    int u_in [2] = '{1000, 3000};
    do_clr();
    set_coefs(8192, 8192, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      run_sample(0, u_in[i], y, oc, ov, lat, tmo);
      tests++;
      if (tmo || y !== longint'(exp_y[i])) begin
        fails++;
        $display("FIX: fir_avg[%0d] got %0d want %0d tmo=%b", i, y, exp_y[i], tmo);
        $display("FAIL fir_avg[%0d]: got %0d want %0d", i, y, exp_y[i]);
      end
    end
  endtask

  task automatic test_recursive();
    longint y; int oc, lat; bit ov, tmo;
    int exp_y [3] = '{1000, 500, 250};
    int u_in [3] = '{1000, 0, 0};
    do_clr();
    set_coefs(16384, 0, 0, -8192, 0);
    for (int i = 0; i < 3; i++) begin
      run_sample(0, u_in[i], y, oc, ov, lat, tmo);
      tests++;
      if (tmo || y !== longint'(exp_y[i])) begin
        fails++;
        $display("FAIL recursive[%0d]: got %0d want %0d tmo=%b", i, y, exp_y[i], tmo);
      end
    end
  endtask

  task automatic test_saturation();
    longint y; int oc, lat; bit ov, tmo;
    int u_in [2] = '{20000, -20000};
    int exp_y [2] = '{32767, -32768};
    do_clr();
    set_coefs(32767, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      run_sample(0, u_in[i], y, oc, ov, lat, tmo);
      tests++;
      if (tmo || y !== longint'(exp_y[i]) || ov !== 1'b1) begin
        fails++;
        $display("FAIL saturation[%0d]: got yk=%0d ovf=%b want %0d 1", i, y, ov, exp_y[i]);
      end
    end
  endtask

  task automatic test_channel_iso();
    longint y; int oc, lat; bit ov, tmo;
    int chs [4] = '{0, 1, 0, 1};
    int u_in [4] = '{1000, 2000, 0, 0};
    int exp_y [4] = '{1000, 2000, 500, 1000};
    do_clr();
    set_coefs(16384, 0, 0, -8192, 0);
    for (int i = 0; i < 4; i++) begin
      run_sample(chs[i], u_in[i], y, oc, ov, lat, tmo);
      tests++;
      if (tmo || y !== longint'(exp_y[i]) || oc !== chs[i]) begin
        fails++;
        $display("FAIL chan_iso[%0d]: got yk=%0d ch=%0d want %0d %0d", i, y, oc, exp_y[i], chs[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    longint y; int oc, lat; bit ov, tmo;
    int bad = 0;
    do_clr();
    set_coefs(16384, 0, 0, 0, 0);
    out_ready = 1'b0;
    run_sample(1, -1234, y, oc, ov, lat, tmo);
    tests++;
    if (tmo || y !== -1234 || oc !== 1) begin
      fails++;
      $display("FAIL bp_first: got yk=%0d ch=%0d want -1234 1", y, oc);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || yk !== -16'sd1234 || out_ch !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    longint y; int oc, lat; bit ov, tmo;
    int seen = 0;
    int exp_y [2] = '{1000, 500};
    int u_in [2] = '{1000, 0};
    do_clr();
    set_coefs(16384, 0, 0, -8192, 0);
    run_sample(0, 3000, y, oc, ov, lat, tmo);
    @(negedge clk);
    in_valid = 1'b1; in_ch = 1'b0; uk = 16'sd5000;
    b0 = cb0; b1 = cb1; b2 = cb2; a1 = ca1; a2 = ca2;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clear();
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    // clr in IDLE wins over a concurrent sample.
    in_valid = 1'b1; clr = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL clr_blocks_ready: got %b want 0", in_ready);
    end
    @(negedge clk); in_valid = 1'b0; clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
    end
    for (int i = 0; i < 2; i++) begin
      run_sample(0, u_in[i], y, oc, ov, lat, tmo);
      tests++;
      if (tmo || y !== longint'(exp_y[i])) begin
        fails++;
        $display("FAIL abort_impulse[%0d]: got %0d want %0d", i, y, exp_y[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    longint y; int oc, lat; bit ov, tmo;
    do_clr();
    set_coefs(16384, 0, 0, -8192, 0);
    run_sample(0, 4000, y, oc, ov, lat, tmo);
    @(negedge clk);
    in_valid = 1'b1; in_ch = 1'b0; uk = 16'sd700;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || yk !== 16'sd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: got valid=%b yk=%0d ready=%b want 0 0 1", out_valid, yk, in_ready);
    end
    @(negedge clk); reset = 1'b1;
    model_clear();
    run_sample(0, 0, y, oc, ov, lat, tmo);
    tests++;
    if (tmo || y !== 0) begin
      fails++;
      $display("FAIL reset_history: got %0d want 0", y);
    end
  endtask

  task automatic test_random();
    longint y, ey; int oc, lat, ch, u; bit ov, eo, tmo;
    do_clr();
    for (int i = 0; i < 40; i++) begin
      ch = int'($urandom_range(0, NCH - 1));
      u  = int'($signed(16'($urandom)));
      if (i < 20) set_coefs(int'($urandom_range(0, 16384)), int'($urandom_range(0, 8192)),
                            int'($urandom_range(0, 4096)), -int'($urandom_range(0, 8192)),
                            int'($urandom_range(0, 4096)));
      else set_coefs(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                     int'($urandom));
      model_step(ch, longint'(u), ey, eo);
      run_sample(ch, u, y, oc, ov, lat, tmo);
      tests++;
      if (tmo || y !== ey || ov !== eo || oc !== ch || lat !== 8) begin
        fails++;
        $display("FAIL random[%0d]: got yk=%0d ovf=%b ch=%0d lat=%0d want %0d %b %0d 8",
                 i, y, ov, oc, lat, ey, eo, ch);
      end
    end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ch = '0; uk = '0; b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    set_coefs(0, 0, 0, 0, 0);
    model_clear();
    repeat (3) @(negedge clk);
    test_reset();
    test_passthrough();
    test_fir();
    test_recursive();
    test_saturation();
    test_channel_iso();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
